// File: rtl/vec_writeback.sv
// -----------------------------------------------------------------------------
// vec_writeback
//   Last stage of the vector ALU. It accepts one 16-lane, 64-bit-per-lane
//   result and writes it into the 512-bit vector register file.
//     wide mode   : two beats, lanes 0-7 to dest_lo, then lanes 8-15 to dest_hi
//     narrow mode : one beat to dest_lo, each lane cut (truncate) or clamped
//                   (saturate) to a signed 32-bit element
//
// Handshakes (valid/ready, both sides):
//   A transfer happens in a cycle where valid and ready are both 1 at the
//   rising edge. Once valid is raised the producer holds its payload until it
//   sees ready. res_ready is a decode of registered state and rst_n only, so
//   there is no combinational path from res_valid. On the register-file side
//   wr_en/wr_addr/wr_data hold steady while wr_ready is 0.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   res_valid/res_ready   result handshake from the ALU
//   res_data              16 signed 64-bit lanes, lane i = res_data[64i+:64]
//   dest_lo, dest_hi      destination registers (dest_hi used in wide mode)
//   narrow, sat_en        single-beat packed writeback / saturate vs truncate
//   wr_en/wr_addr/wr_data register-file write beat
//   wr_ready              register file takes the beat this cycle
//   done                  1-cycle pulse on the final accepted beat
//   ovf                   with done: some lane was clamped (narrow saturate)
// -----------------------------------------------------------------------------
module vec_writeback #(
  parameter int LANES   = 16,
  parameter int LANE_W  = 64,
  parameter int ELEM_W  = 32,
  parameter int RADDR_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [LANES*LANE_W-1:0]   res_data,
  input  logic [RADDR_W-1:0]        dest_lo,
  input  logic [RADDR_W-1:0]        dest_hi,
  input  logic                      narrow,
  input  logic                      sat_en,
  output logic                      wr_en,
  output logic [RADDR_W-1:0]        wr_addr,
  output logic [LANES*ELEM_W-1:0]   wr_data,
  input  logic                      wr_ready,
  output logic                      done,
  output logic                      ovf
);

  localparam int RES_W  = LANES * LANE_W;
  localparam int DATA_W = LANES * ELEM_W;
  // One wide beat carries half the lanes; with the default geometry this is
  // exactly one register-file word.
  localparam int HALF_W = RES_W / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_LO = 2'd1,
    S_WR_HI = 2'd2
  } state_e;

  state_e               state_q,   state_d;
  logic [RES_W-1:0]     data_q,    data_d;
  logic [RADDR_W-1:0]   dest_lo_q, dest_lo_d;
  logic [RADDR_W-1:0]   dest_hi_q, dest_hi_d;
  logic                 narrow_q,  narrow_d;
  logic                 sat_q,     sat_d;

  // Narrow packing, computed from the capture buffer.
  logic [LANES-1:0]     clamp;
  logic [DATA_W-1:0]    narrow_data;

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    logic [LANE_W-1:0]   lane;
    logic [LANE_W-ELEM_W:0] upper;   // sign-extension bits incl. element MSB
    logic                fits;
    assign lane  = data_q[i*LANE_W +: LANE_W];
    assign upper = lane[LANE_W-1:ELEM_W-1];
    // The lane fits a signed element iff bits [63:31] are all equal.
    assign fits  = (&upper) | ~(|upper);
    assign clamp[i] = sat_q & ~fits;
    assign narrow_data[i*ELEM_W +: ELEM_W] =
      !clamp[i]           ? lane[ELEM_W-1:0] :
      lane[LANE_W-1]      ? {1'b1, {(ELEM_W-1){1'b0}}} :
                            {1'b0, {(ELEM_W-1){1'b1}}};
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dest_lo_d = dest_lo_q;
    dest_hi_d = dest_hi_q;
    narrow_d  = narrow_q;
    sat_d     = sat_q;
    res_ready = (state_q == S_IDLE) && rst_n;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;
    ovf       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (res_valid && res_ready) begin
          data_d    = res_data;
          dest_lo_d = dest_lo;
          dest_hi_d = dest_hi;
          narrow_d  = narrow;
          sat_d     = sat_en;
          state_d   = S_WR_LO;
        end
      end
      S_WR_LO: begin
        wr_en   = 1'b1;
        wr_addr = dest_lo_q;
        wr_data = narrow_q ? narrow_data : data_q[HALF_W-1:0];
        if (wr_ready) begin
          if (narrow_q) begin
            done    = 1'b1;
            ovf     = |clamp;
            state_d = S_IDLE;
          end else begin
            state_d = S_WR_HI;
          end
        end
      end
      S_WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = dest_hi_q;
        wr_data = data_q[RES_W-1:HALF_W];
        if (wr_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A beat pending while reset is asserted is dropped, not written.
    if (!rst_n) begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      done    = 1'b0;
      ovf     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      dest_lo_q <= '0;
      dest_hi_q <= '0;
      narrow_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dest_lo_q <= dest_lo_d;
      dest_hi_q <= dest_hi_d;
      narrow_q  <= narrow_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_vec_writeback.sv
// -----------------------------------------------------------------------------
// tb_vec_writeback
//   Directed vectors for vec_writeback. Each handshake pushes the expected
//   write beats (addr, data, done, ovf) into exp_q; a monitor on the falling
//   edge pops one entry per accepted beat and compares. Stalled beats are
//   compared against the head entry without popping; idle cycles must show
//   all-zero outputs.
// -----------------------------------------------------------------------------
module tb_vec_writeback;

  localparam int RES_W  = 1024;
  localparam int DATA_W = 512;
  localparam int EXP_W  = 2 + DATA_W + 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                res_valid;
  logic                res_ready;
  logic [RES_W-1:0]    res_data;
  logic [1:0]          dest_lo, dest_hi;
  logic                narrow, sat_en;
  logic                wr_en;
  logic [1:0]          wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_ready;
  logic                done, ovf;

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  vec_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .dest_lo   (dest_lo),
    .dest_hi   (dest_hi),
    .narrow    (narrow),
    .sat_en    (sat_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .done      (done),
    .ovf       (ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- compare helper ----------------
  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: addr %0h with empty queue", wr_addr);
      end else begin
        e = exp_q[0];
        chk("beat_addr", DATA_W'(wr_addr), DATA_W'(e[EXP_W-1 -: 2]));
        chk("beat_data", wr_data, e[DATA_W+1:2]);
        if (wr_ready) begin
          chk("beat_done", DATA_W'(done), DATA_W'(e[1]));
          chk("beat_ovf",  DATA_W'(ovf),  DATA_W'(e[0]));
          void'(exp_q.pop_front());
        end else begin
          chk("stall_done", DATA_W'({done, ovf}), '0);
        end
      end
    end else begin
      chk("idle_wr_en", DATA_W'(wr_en), '0);
      chk("idle_outs", DATA_W'({wr_addr, done, ovf}), '0);
      chk("idle_data", wr_data, '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [1:0] a, input logic [DATA_W-1:0] d,
                           input logic dn, input logic ov);
    exp_q.push_back({a, d, dn, ov});
  endtask

  // Offers one result and returns after the accepting edge (#1 later).
  // waits = number of falling edges at which res_ready was still 0.
  task automatic send(input logic [RES_W-1:0] d, input logic [1:0] lo,
                      input logic [1:0] hi, input logic nar, input logic sat,
                      output int waits);
    waits = 0;
    @(negedge clk);
    res_valid = 1'b1;
    res_data  = d;
    dest_lo   = lo;
    dest_hi   = hi;
    narrow    = nar;
    sat_en    = sat;
    while (res_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: res_ready never rose");
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    // Scramble the inputs: the stage must work from its capture buffer.
    res_data  = {32{$urandom()}};
    dest_lo   = 2'($urandom_range(0, 3));
    dest_hi   = 2'($urandom_range(0, 3));
    narrow    = 1'($urandom_range(0, 1));
    sat_en    = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [RES_W-1:0]  d;
    logic [DATA_W-1:0] lo_exp, hi_exp;
    int w;

    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    dest_lo   = '0;
    dest_hi   = '0;
    narrow    = 1'b0;
    sat_en    = 1'b0;
    wr_ready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_res_ready", DATA_W'(res_ready), '0);
    chk("reset_wr_en", DATA_W'(wr_en), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_res_ready", DATA_W'(res_ready), DATA_W'(1));

    // 1. Wide, no stall: lane i = i+1
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'(i + 1);
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = 64'(j + 1);
      hi_exp[64*j +: 64] = 64'(j + 9);
    end
    send(d, 2'd0, 2'd1, 1'b0, 1'b0, w);
    push_beat(2'd0, lo_exp, 1'b0, 1'b0);
    push_beat(2'd1, hi_exp, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_n1_wr_en", DATA_W'({wr_en, res_ready, done}), DATA_W'(3'b100));
    @(negedge clk);
    chk("t1_n2_wr_en", DATA_W'({wr_en, res_ready, done}), DATA_W'(3'b101));
    @(negedge clk);
    chk("t1_n3_ready", DATA_W'({wr_en, res_ready}), DATA_W'(2'b01));

    // 2. Narrow truncate
    for (int i = 0; i < 16; i++) d[64*i +: 64] = '1;
    d[63:0] = 64'h0000_0001_8000_0005;
    for (int i = 0; i < 16; i++) lo_exp[32*i +: 32] = 32'hFFFF_FFFF;
    lo_exp[31:0] = 32'h8000_0005;
    send(d, 2'd2, 2'd3, 1'b1, 1'b0, w);
    push_beat(2'd2, lo_exp, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_n1_done", DATA_W'({wr_en, done, res_ready}), DATA_W'(3'b110));
    @(negedge clk);
    chk("t2_n2_ready", DATA_W'(res_ready), DATA_W'(1));

    // 3. Narrow saturate, two clamped lanes; back-to-back narrow follow-up
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'd7;
    d[63:0]    = 64'h0000_0000_8000_0000;
    d[127:64]  = 64'hFFFF_FFFF_7FFF_FFFF;
    for (int i = 0; i < 16; i++) lo_exp[32*i +: 32] = 32'd7;
    lo_exp[31:0]  = 32'h7FFF_FFFF;
    lo_exp[63:32] = 32'h8000_0000;
    send(d, 2'd1, 2'd0, 1'b1, 1'b1, w);
    push_beat(2'd1, lo_exp, 1'b1, 1'b1);

    // 3b. Saturate at the exact limits: nothing clamps, ovf stays 0
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'hFFFF_FFFF_FFFF_FFFB;
    d[63:0]   = 64'h0000_0000_7FFF_FFFF;
    d[127:64] = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 16; i++) lo_exp[32*i +: 32] = 32'hFFFF_FFFB;
    lo_exp[31:0]  = 32'h7FFF_FFFF;
    lo_exp[63:32] = 32'h8000_0000;
    send(d, 2'd3, 2'd0, 1'b1, 1'b1, w);
    chk("t3b_narrow_waits", DATA_W'(w), DATA_W'(1));
    push_beat(2'd3, lo_exp, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // 4. Stall: wr_ready low for the first 3 WR_LO cycles
    for (int i = 0; i < 16; i++) d[64*i +: 64] = {32'hCAFE_0000, 32'(i)};
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = {32'hCAFE_0000, 32'(j)};
      hi_exp[64*j +: 64] = {32'hCAFE_0000, 32'(j + 8)};
    end
    wr_ready = 1'b0;
    send(d, 2'd3, 2'd2, 1'b0, 1'b0, w);
    push_beat(2'd3, lo_exp, 1'b0, 1'b0);
    push_beat(2'd2, hi_exp, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall", DATA_W'({wr_en, res_ready, done}), DATA_W'(3'b100));
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    @(negedge clk);
    chk("t4_lo_accept", DATA_W'({wr_addr, res_ready, done}), DATA_W'(4'b1100));
    @(negedge clk);
    chk("t4_hi_accept", DATA_W'({wr_addr, res_ready, done}), DATA_W'(4'b1001));
    repeat (2) @(negedge clk);

    // 5. Backpressure: second result offered straight after the first
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'h100 + 64'(i);
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = 64'h100 + 64'(j);
      hi_exp[64*j +: 64] = 64'h108 + 64'(j);
    end
    send(d, 2'd2, 2'd1, 1'b0, 1'b0, w);
    push_beat(2'd2, lo_exp, 1'b0, 1'b0);
    push_beat(2'd1, hi_exp, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'h200 + 64'(i);
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = 64'h200 + 64'(j);
      hi_exp[64*j +: 64] = 64'h208 + 64'(j);
    end
    send(d, 2'd0, 2'd3, 1'b0, 1'b0, w);
    chk("t5_wide_waits", DATA_W'(w), DATA_W'(2));
    push_beat(2'd0, lo_exp, 1'b0, 1'b0);
    push_beat(2'd3, hi_exp, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Wide with dest_hi == dest_lo: both beats still issued
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'(i) * 64'h1111_0000_1111;
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = 64'(j) * 64'h1111_0000_1111;
      hi_exp[64*j +: 64] = 64'(j + 8) * 64'h1111_0000_1111;
    end
    send(d, 2'd2, 2'd2, 1'b0, 1'b1, w);
    push_beat(2'd2, lo_exp, 1'b0, 1'b0);
    push_beat(2'd2, hi_exp, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // 6. Reset for one cycle while in WR_LO
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'hBAD0 + 64'(i);
    send(d, 2'd1, 2'd2, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_in_reset", DATA_W'({wr_en, done, res_ready}), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_reset", DATA_W'({wr_en, done, res_ready}), DATA_W'(3'b001));
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'hF00D_0000 + 64'(i);
    for (int j = 0; j < 8; j++) begin
      lo_exp[64*j +: 64] = 64'hF00D_0000 + 64'(j);
      hi_exp[64*j +: 64] = 64'hF00D_0008 + 64'(j);
    end
    send(d, 2'd3, 2'd0, 1'b0, 1'b0, w);
    chk("t6_follow_waits", DATA_W'(w), '0);
    push_beat(2'd3, lo_exp, 1'b0, 1'b0);
    push_beat(2'd0, hi_exp, 1'b1, 1'b0);

    // Drain
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue_empty", DATA_W'(exp_q.size()), '0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
